// File: rtl/acu_plank_pkg.sv
// Shared constants, frame kinds and FSM state encoding for the ACU/plank
// serial frame parser.
package acu_plank_pkg;

    localparam logic [7:0] HDR_BYTE     = 8'hAA;
    localparam logic [7:0] FTR_BYTE     = 8'h55;
    localparam logic [7:0] SNSR_PAYLOAD = 8'h11;

    localparam logic [3:0] TYPE_ACU   = 4'h1;
    localparam logic [3:0] TYPE_PLANK = 4'h2;
    localparam logic [3:0] TYPE_SNSR  = 4'h4;

    localparam int LEN_ACU     = 5;
    localparam int LEN_PLANK   = 18;
    localparam int LEN_SNSR    = 1;
    localparam int PLANK_DEPTH = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_PAYLOAD,
        ST_CHKSUM,
        ST_FOOTER
    } fsm_state_t;

    typedef enum logic [1:0] {
        FT_ACU,
        FT_PLANK,
        FT_SNSR
    } frame_kind_t;

    // Index of the final payload byte for a given frame kind.
    function automatic logic [4:0] last_idx(frame_kind_t kind);
        case (kind)
            FT_ACU:   return 5'(LEN_ACU - 1);
            FT_PLANK: return 5'(LEN_PLANK - 1);
            default:  return 5'(LEN_SNSR - 1);
        endcase
    endfunction

endpackage

// File: rtl/inter_byte_timer.sv
// Inter-byte watchdog: down-counter reloaded on clear or while idle,
// emitting a one-cycle expired pulse at terminal count.
module inter_byte_timer #(
    parameter int g_CYCLES = 100000
) (
    input  logic i_clk_100,
    input  logic i_rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int              W    = $clog2(g_CYCLES + 1);
    localparam logic [W-1:0]    LOAD = W'(g_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= LOAD;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (clear || !run) begin
                cnt <= LOAD;
            end else if (cnt != '0) begin
                cnt     <= cnt - W'(1);
                expired <= (cnt == W'(1));
            end
        end
    end

endmodule

// File: rtl/acu_frame_parser.sv
// Parses ACU / PLANK / SNSR frames from the UART byte stream and drives the
// latched ACU registers, the plank write port and the status pulses.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for header 0xAA, other bytes silently dropped
// ST_TYPE    | expecting type byte, selects frame kind
// ST_PAYLOAD | collecting payload into shadows / plank write port
// ST_CHKSUM  | comparing running XOR with received checksum
// ST_FOOTER  | expecting 0x55, commits shadows or flags an error
module acu_frame_parser
    import acu_plank_pkg::*;
#(
    parameter int g_TIMEOUT_CYC = 100000
) (
    input  logic       i_clk_100,
    input  logic       i_rst_n,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic [3:0] o_enable,
    output logic [5:0] o_ATT1,
    output logic [5:0] o_ATT2,
    output logic [5:0] o_ATT3,
    output logic [5:0] o_ATT4,
    output logic       o_BITE_CNTRL,
    output logic       o_SUB_ARRAY,
    output logic       o_acu_valid,
    output logic       o_plank_wr_en,
    output logic [4:0] o_plank_wr_addr,
    output logic [7:0] o_plank_wr_data,
    output logic       o_plank_valid,
    output logic [2:0] o_plank_sel,
    output logic       o_snsr_req,
    output logic       o_frame_err
);

    fsm_state_t       state;
    frame_kind_t      kind;
    logic [4:0]       idx;
    logic [7:0]       chk;
    logic             chk_ok;
    logic             snsr_ok;
    logic [3:0]       sh_enable;
    logic [3:0][5:0]  sh_att;
    logic             sh_bite;
    logic             sh_sub;
    logic [2:0]       sh_sel;
    logic             timer_exp;

    inter_byte_timer #(
        .g_CYCLES (g_TIMEOUT_CYC)
    ) u_timer (
        .i_clk_100 (i_clk_100),
        .i_rst_n   (i_rst_n),
        .clear     (i_rx_dv),
        .run       (state != ST_IDLE),
        .expired   (timer_exp)
    );

    always_ff @(posedge i_clk_100 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            kind            <= FT_ACU;
            idx             <= '0;
            chk             <= '0;
            chk_ok          <= 1'b0;
            snsr_ok         <= 1'b0;
            sh_enable       <= '0;
            sh_att          <= '0;
            sh_bite         <= 1'b0;
            sh_sub          <= 1'b0;
            sh_sel          <= '0;
            o_enable        <= '0;
            o_ATT1          <= '0;
            o_ATT2          <= '0;
            o_ATT3          <= '0;
            o_ATT4          <= '0;
            o_BITE_CNTRL    <= 1'b0;
            o_SUB_ARRAY     <= 1'b0;
            o_acu_valid     <= 1'b0;
            o_plank_wr_en   <= 1'b0;
            o_plank_wr_addr <= '0;
            o_plank_wr_data <= '0;
            o_plank_valid   <= 1'b0;
            o_plank_sel     <= '0;
            o_snsr_req      <= 1'b0;
            o_frame_err     <= 1'b0;
        end else begin
            o_acu_valid   <= 1'b0;
            o_plank_valid <= 1'b0;
            o_snsr_req    <= 1'b0;
            o_frame_err   <= 1'b0;
            o_plank_wr_en <= 1'b0;

            // A byte arriving in the expiry cycle takes priority over the timeout.
            if (i_rx_dv) begin
                case (state)
                    ST_IDLE: begin
                        if (i_rx_byte == HDR_BYTE) begin
                            chk   <= i_rx_byte;
                            state <= ST_TYPE;
                        end
                    end
                    ST_TYPE: begin
                        chk   <= chk ^ i_rx_byte;
                        idx   <= '0;
                        state <= ST_PAYLOAD;
                        case (i_rx_byte[3:0])
                            TYPE_ACU: begin
                                kind      <= FT_ACU;
                                sh_enable <= i_rx_byte[7:4];
                            end
                            TYPE_PLANK: kind <= FT_PLANK;
                            TYPE_SNSR:  kind <= FT_SNSR;
                            default: begin
                                o_frame_err <= 1'b1;
                                state       <= ST_IDLE;
                            end
                        endcase
                    end
                    ST_PAYLOAD: begin
                        chk <= chk ^ i_rx_byte;
                        idx <= idx + 5'd1;
                        if (idx == last_idx(kind)) state <= ST_CHKSUM;
                        case (kind)
                            FT_ACU: begin
                                if (idx < 5'd4) begin
                                    sh_att[idx[1:0]] <= i_rx_byte[5:0];
                                end else begin
                                    sh_bite <= i_rx_byte[0];
                                    sh_sub  <= i_rx_byte[1];
                                end
                            end
                            FT_PLANK: begin
                                // Writes go out immediately; the consumer only keeps them on o_plank_valid.
                                if (idx < 5'(PLANK_DEPTH)) begin
                                    o_plank_wr_en   <= 1'b1;
                                    o_plank_wr_addr <= idx;
                                    o_plank_wr_data <= i_rx_byte;
                                end else begin
                                    sh_sel <= i_rx_byte[2:0];
                                end
                            end
                            FT_SNSR: snsr_ok <= (i_rx_byte == SNSR_PAYLOAD);
                            default: ;
                        endcase
                    end
                    ST_CHKSUM: begin
                        chk_ok <= (i_rx_byte == chk);
                        state  <= ST_FOOTER;
                    end
                    ST_FOOTER: begin
                        state <= ST_IDLE;
                        if (i_rx_byte == FTR_BYTE && chk_ok && (kind != FT_SNSR || snsr_ok)) begin
                            case (kind)
                                FT_ACU: begin
                                    o_enable     <= sh_enable;
                                    o_ATT1       <= sh_att[0];
                                    o_ATT2       <= sh_att[1];
                                    o_ATT3       <= sh_att[2];
                                    o_ATT4       <= sh_att[3];
                                    o_BITE_CNTRL <= sh_bite;
                                    o_SUB_ARRAY  <= sh_sub;
                                    o_acu_valid  <= 1'b1;
                                end
                                FT_PLANK: begin
                                    o_plank_sel   <= sh_sel;
                                    o_plank_valid <= 1'b1;
                                end
                                FT_SNSR: o_snsr_req <= 1'b1;
                                default: o_frame_err <= 1'b1;
                            endcase
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (timer_exp && state != ST_IDLE) begin
                o_frame_err <= 1'b1;
                state       <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_acu_frame_parser.sv
// Directed bench for acu_frame_parser with a shortened inter-byte timeout.
module tb_acu_frame_parser;

    localparam int T = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;

    logic [3:0] o_enable;
    logic [5:0] o_ATT1, o_ATT2, o_ATT3, o_ATT4;
    logic       o_BITE_CNTRL, o_SUB_ARRAY, o_acu_valid;
    logic       o_plank_wr_en;
    logic [4:0] o_plank_wr_addr;
    logic [7:0] o_plank_wr_data;
    logic       o_plank_valid;
    logic [2:0] o_plank_sel;
    logic       o_snsr_req, o_frame_err;

    acu_frame_parser #(.g_TIMEOUT_CYC(T)) dut (
        .i_clk_100       (clk),
        .i_rst_n         (rst_n),
        .i_rx_dv         (rx_dv),
        .i_rx_byte       (rx_byte),
        .o_enable        (o_enable),
        .o_ATT1          (o_ATT1),
        .o_ATT2          (o_ATT2),
        .o_ATT3          (o_ATT3),
        .o_ATT4          (o_ATT4),
        .o_BITE_CNTRL    (o_BITE_CNTRL),
        .o_SUB_ARRAY     (o_SUB_ARRAY),
        .o_acu_valid     (o_acu_valid),
        .o_plank_wr_en   (o_plank_wr_en),
        .o_plank_wr_addr (o_plank_wr_addr),
        .o_plank_wr_data (o_plank_wr_data),
        .o_plank_valid   (o_plank_valid),
        .o_plank_sel     (o_plank_sel),
        .o_snsr_req      (o_snsr_req),
        .o_frame_err     (o_frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int acu_cnt = 0, plank_cnt = 0, snsr_cnt = 0, err_cnt = 0, wr_total = 0;
    int a0, p0, s0, e0, w0;
    logic [4:0] wr_addr_log [64];
    logic [7:0] wr_data_log [64];
    logic [2:0] sel_at_valid = 3'd0;
    logic [7:0] fq [$];

    always @(negedge clk) begin
        if (o_acu_valid)   acu_cnt++;
        if (o_snsr_req)    snsr_cnt++;
        if (o_frame_err)   err_cnt++;
        if (o_plank_valid) begin
            plank_cnt++;
            sel_at_valid = o_plank_sel;
        end
        if (o_plank_wr_en) begin
            if (wr_total < 64) begin
                wr_addr_log[wr_total] = o_plank_wr_addr;
                wr_data_log[wr_total] = o_plank_wr_data;
            end
            wr_total++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv   = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_q(input int gap);
        for (int i = 0; i < fq.size(); i++) send_byte(fq[i], gap);
    endtask

    task automatic snap();
        a0 = acu_cnt; p0 = plank_cnt; s0 = snsr_cnt; e0 = err_cnt; w0 = wr_total;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_att"}, {8'h0, o_ATT1, o_ATT2, o_ATT3, o_ATT4}, 32'h0);
        check_val({tag, "_ctrl"}, {23'h0, o_enable, o_BITE_CNTRL, o_SUB_ARRAY, o_plank_sel}, 32'h0);
        check_val({tag, "_pulse"}, {27'h0, o_acu_valid, o_plank_valid, o_snsr_req, o_frame_err, o_plank_wr_en}, 32'h0);
        check_val({tag, "_wrport"}, {19'h0, o_plank_wr_addr, o_plank_wr_data}, 32'h0);
    endtask

    initial begin
        int bad;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // non-header bytes in IDLE are dropped silently
        snap();
        send_byte(8'h12, 1);
        send_byte(8'h55, 1);
        settle();
        check_val("idle_discard_err", err_cnt - e0, 0);

        // good ACU frame, footer latency
        snap();
        fq = {8'hAA, 8'hF1, 8'h33, 8'h2A, 8'h38, 8'h24, 8'h03, 8'h5D};
        send_q(1);
        send_byte(8'h55, 0);
        check_val("acu_valid_latency", {31'h0, o_acu_valid}, 32'h1);
        check_val("acu_enable", {28'h0, o_enable}, 32'hF);
        check_val("acu_att", {8'h0, o_ATT1, o_ATT2, o_ATT3, o_ATT4}, {8'h0, 6'h33, 6'h2A, 6'h38, 6'h24});
        check_val("acu_bits", {30'h0, o_BITE_CNTRL, o_SUB_ARRAY}, 32'h3);
        @(posedge clk); #1;
        check_val("acu_valid_one_cycle", {31'h0, o_acu_valid}, 32'h0);
        settle();
        check_val("acu_valid_cnt", acu_cnt - a0, 1);
        check_val("acu_err_cnt", err_cnt - e0, 0);

        // same frame, checksum 5C
        snap();
        fq = {8'hAA, 8'hF1, 8'h33, 8'h2A, 8'h38, 8'h24, 8'h03, 8'h5C, 8'h55};
        send_q(1);
        settle();
        check_val("badchk_err", err_cnt - e0, 1);
        check_val("badchk_valid", acu_cnt - a0, 0);

        // different payload, wrong checksum: outputs must stay
        snap();
        fq = {8'hAA, 8'hA1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h55};
        send_q(1);
        settle();
        check_val("badchk2_err", err_cnt - e0, 1);
        check_val("badchk2_hold", {4'h0, o_enable, o_ATT1, o_ATT2, o_ATT3, o_ATT4}, {4'h0, 4'hF, 6'h33, 6'h2A, 6'h38, 6'h24});

        // correct checksum, bad footer
        snap();
        fq = {8'hAA, 8'hA1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h0F, 8'h54};
        send_q(1);
        settle();
        check_val("badftr_err", err_cnt - e0, 1);
        check_val("badftr_hold", {28'h0, o_enable}, 32'hF);
        check_val("badftr_valid", acu_cnt - a0, 0);

        // good SNSR frame
        snap();
        fq = {8'hAA, 8'h04, 8'h11, 8'hBF, 8'h55};
        send_q(1);
        settle();
        check_val("snsr_req", snsr_cnt - s0, 1);
        check_val("snsr_err", err_cnt - e0, 0);

        // SNSR with wrong payload but consistent checksum
        snap();
        fq = {8'hAA, 8'h04, 8'h12, 8'hBC, 8'h55};
        send_q(1);
        settle();
        check_val("snsr_bad_err", err_cnt - e0, 1);
        check_val("snsr_bad_req", snsr_cnt - s0, 0);

        // unknown type nibble
        snap();
        fq = {8'hAA, 8'h03};
        send_q(1);
        settle();
        check_val("badtype_err", err_cnt - e0, 1);

        // PLANK frame
        snap();
        fq = {8'hAA, 8'hE2};
        for (int i = 0; i < 17; i++) fq.push_back(8'h32);
        fq.push_back(8'h01);
        fq.push_back(8'h7B);
        fq.push_back(8'h55);
        send_q(1);
        settle();
        check_val("plank_wr_cnt", wr_total - w0, 17);
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            if ((w0 + i) < 64) begin
                if (wr_addr_log[w0 + i] !== 5'(i) || wr_data_log[w0 + i] !== 8'h32) bad++;
            end
        end
        check_val("plank_wr_content", bad, 0);
        check_val("plank_valid", plank_cnt - p0, 1);
        check_val("plank_sel", {29'h0, sel_at_valid}, 32'h1);
        check_val("plank_err", err_cnt - e0, 0);

        // 0xAA inside payload is data
        snap();
        fq = {8'hAA, 8'h51, 8'hAA, 8'h15, 8'h00, 8'h3F, 8'h02, 8'h79, 8'h55};
        send_q(1);
        settle();
        check_val("midaa_valid", acu_cnt - a0, 1);
        check_val("midaa_regs", {o_enable, o_ATT1, o_ATT2, o_ATT3, o_ATT4, o_BITE_CNTRL, o_SUB_ARRAY, 2'b0},
                  {4'h5, 6'h2A, 6'h15, 6'h00, 6'h3F, 1'b0, 1'b1, 2'b0});

        // stall after byte 4 well beyond the timeout
        snap();
        fq = {8'hAA, 8'hF1, 8'h33, 8'h2A};
        send_q(1);
        send_byte(8'h38, T + 5);
        fq = {8'h24, 8'h03, 8'h5D, 8'h55};
        send_q(1);
        settle();
        check_val("timeout_err", err_cnt - e0, 1);
        check_val("timeout_valid", acu_cnt - a0, 0);
        check_val("timeout_hold", {28'h0, o_enable}, 32'h5);
        snap();
        fq = {8'hAA, 8'hF1, 8'h33, 8'h2A, 8'h38, 8'h24, 8'h03, 8'h5D, 8'h55};
        send_q(1);
        settle();
        check_val("after_timeout_valid", acu_cnt - a0, 1);
        check_val("after_timeout_enable", {28'h0, o_enable}, 32'hF);

        // inter-byte gaps just under the timeout
        snap();
        fq = {8'hAA, 8'h51, 8'hAA, 8'h15, 8'h00, 8'h3F, 8'h02, 8'h79, 8'h55};
        send_q(T - 2);
        settle();
        check_val("slow_err", err_cnt - e0, 0);
        check_val("slow_valid", acu_cnt - a0, 1);
        check_val("slow_enable", {28'h0, o_enable}, 32'h5);

        // reset mid-PLANK
        snap();
        fq = {8'hAA, 8'hE2, 8'h32, 8'h32, 8'h32, 8'h32, 8'h32};
        send_q(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        fq = {8'hAA, 8'h04, 8'h11, 8'hBF, 8'h55};
        send_q(1);
        settle();
        check_val("midrst_no_plank_valid", plank_cnt - p0, 0);
        check_val("midrst_snsr", snsr_cnt - s0, 1);
        check_val("midrst_err", err_cnt - e0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/acu_frame_parser.md
ACU_FRAME_PARSER -- requirements
Module: acu_frame_parser

Interface
REQ-001 The parameter g_TIMEOUT_CYC SHALL default to 100000 and give the inter-byte timeout in i_clk_100 cycles (1 ms).
REQ-002 i_clk_100  in  1  single 100 MHz clock; all logic SHALL be clocked on its rising edge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_rx_dv  in  1  one-cycle strobe from the ACU UART receiver marking a valid byte.
REQ-005 i_rx_byte  in  8  received byte, valid while i_rx_dv=1.
REQ-006 o_enable  out  4  latched channel enables.
REQ-007 o_ATT1, o_ATT2, o_ATT3, o_ATT4  out  6 each  latched attenuator words.
REQ-008 o_BITE_CNTRL, o_SUB_ARRAY  out  1 each  latched control bits.
REQ-009 o_acu_valid  out  1  one-cycle pulse when ACU registers update.
REQ-010 o_plank_wr_en, o_plank_wr_addr[4:0], o_plank_wr_data[7:0]  out  plank payload write port.
REQ-011 o_plank_valid  out  1  commit pulse; o_plank_sel  out  3  target plank, valid with the pulse.
REQ-012 o_snsr_req  out  1  one-cycle pulse on a valid sensor-request frame.
REQ-013 o_frame_err  out  1  one-cycle pulse on any rejected frame.

Function
REQ-014 Frame format SHALL be: 0xAA, type byte, payload, checksum, 0x55; checksum = XOR of all bytes from header through the last payload byte.
REQ-015 Type byte low nibble SHALL select the frame: 0x1 ACU (5 payload bytes), 0x2 PLANK (18), 0x4 SNSR (1); any other low nibble -> o_frame_err, return to IDLE.
REQ-016 The FSM SHALL have states IDLE, TYPE, PAYLOAD, CHKSUM, FOOTER and advance only on i_rx_dv.
REQ-017 In IDLE, a byte other than 0xAA SHALL be discarded without o_frame_err.
REQ-018 ACU: type[7:4] -> enable; payload bytes 1-4 [5:0] -> ATT1..ATT4 ([7:6] ignored); byte 5 bit0 -> BITE, bit1 -> SUB_ARRAY; these SHALL be shadowed and copied to the outputs only on a good footer.
REQ-019 PLANK: payload bytes 0-16 SHALL each drive o_plank_wr_en for one cycle, with addr 0..16, in the cycle after i_rx_dv; payload byte 17 [2:0] -> o_plank_sel.
REQ-020 SNSR: the payload byte SHALL equal 0x11, otherwise the frame is an error.
REQ-021 Checksum mismatch, footer other than 0x55, or SNSR payload mismatch -> o_frame_err, no commit, outputs unchanged, IDLE.
REQ-022 Latency: o_acu_valid, o_plank_valid, o_snsr_req and updated outputs SHALL appear one cycle after the footer's i_rx_dv.
REQ-023 Inter-byte counter SHALL run in every state except IDLE and clear on each i_rx_dv; reaching g_TIMEOUT_CYC -> o_frame_err, IDLE.
REQ-024 If the timeout and i_rx_dv occur in the same cycle, the byte SHALL win and no error is raised.
REQ-025 A 0xAA received mid-frame SHALL be treated as data, with no resync.
REQ-026 Plank writes already issued before an error SHALL NOT be retracted; the consumer discards them when no o_plank_valid follows.

Reset
REQ-027 Asserting i_rst_n low SHALL immediately force IDLE and clear the counter, the shadows and every output to 0, including a frame in progress.
REQ-028 After release, the first accepted byte SHALL be a 0xAA seen in IDLE.

Structure
REQ-029 Package acu_plank_pkg SHALL hold the header and footer constants (0xAA/0x55), the type codes, the payload lengths, the FSM state enum and the plank payload depth (17).
REQ-030 The inter-byte timeout SHALL be a sub-module, inter_byte_timer (inputs: clear, run; output: expired pulse).

Verification
REQ-031 ACU frame AA F1 33 2A 38 24 03 5D 55 -> o_enable=F, ATT1..ATT4=33/2A/38/24, BITE=1, SUB_ARRAY=1, one o_acu_valid.
REQ-032 Same ACU frame with checksum 5C -> o_frame_err, outputs keep their prior values.
REQ-033 SNSR frame AA 04 11 BF 55 -> one o_snsr_req, no o_frame_err.
REQ-034 PLANK frame AA E2, 17 x 32, 01, 7B, 55 -> 17 writes (addr 0..16, data 32), o_plank_valid with o_plank_sel=1.
REQ-035 ACU frame stalled 1.1 ms after byte 4 -> one o_frame_err, IDLE; a following good frame is accepted.
REQ-036 Reset pulsed mid-PLANK frame -> all outputs 0, no o_plank_valid; a following SNSR frame is accepted.
